// File: rtl/branch_predictor.sv
// Direct-mapped saturating-counter predictor with a tagged target buffer and a 1-cycle registered lookup.
// Optional build macro BP_GSHARE_EN adds a global history register XORed into the table index.
module branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int CNT_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bp_enable,
    output logic                ready,
    input  logic                lk_valid,
    input  logic [31:0]         lk_pc,
    input  logic                lk_stall,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    output logic [GHR_BITS-1:0] pred_hist,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic [GHR_BITS-1:0] upd_hist
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] WNT  = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0] WT   = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] CMAX = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, next_state;
    logic [IDX_BITS-1:0] sweep;

    logic                v_mem   [ENTRIES];
    logic [TAG_BITS-1:0] tag_mem [ENTRIES];
    logic [CNT_BITS-1:0] cnt_mem [ENTRIES];
    logic [31:0]         tgt_mem [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic [GHR_BITS-1:0] hist_now;
    logic                lk_hit, up_hit;
    logic                unused_inputs;

    assign lk_tag = lk_pc[2+IDX_BITS +: TAG_BITS];
    assign up_tag = upd_pc[2+IDX_BITS +: TAG_BITS];

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    // History shifts only on updates the table actually accepts.
    always_ff @(posedge clk) begin
        if (!rst || state == INIT)
            ghr <= '0;
        else if (upd_valid)
            ghr <= GHR_BITS'({ghr, upd_taken});
    end

    assign lk_idx        = lk_pc[2 +: IDX_BITS] ^ IDX_BITS'(ghr);
    assign up_idx        = upd_pc[2 +: IDX_BITS] ^ IDX_BITS'(upd_hist);
    assign hist_now      = ghr;
    assign unused_inputs = ^upd_pc;
`else
    assign lk_idx        = lk_pc[2 +: IDX_BITS];
    assign up_idx        = upd_pc[2 +: IDX_BITS];
    assign hist_now      = '0;
    assign unused_inputs = ^{upd_pc, upd_hist};
`endif

    assign lk_hit = v_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign up_hit = v_mem[up_idx] && (tag_mem[up_idx] == up_tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= next_state;
            if (state == INIT)
                sweep <= sweep + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (state == INIT && sweep == IDX_BITS'(ENTRIES - 1))
            next_state = RUN;
    end

    always_comb begin
        ready = (state == RUN);
    end

    // Table writes: the init sweep clears one entry per cycle, training happens only in RUN.
    always_ff @(posedge clk) begin
        if (rst && state == INIT) begin
            v_mem[sweep]   <= 1'b0;
            cnt_mem[sweep] <= WNT;
        end else if (rst && state == RUN && upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (cnt_mem[up_idx] != CMAX)
                        cnt_mem[up_idx] <= cnt_mem[up_idx] + 1'b1;
                    tgt_mem[up_idx] <= upd_target;
                end else if (cnt_mem[up_idx] != '0) begin
                    cnt_mem[up_idx] <= cnt_mem[up_idx] - 1'b1;
                end
            end else if (upd_taken) begin
                v_mem[up_idx]   <= 1'b1;
                tag_mem[up_idx] <= up_tag;
                cnt_mem[up_idx] <= WT;
                tgt_mem[up_idx] <= upd_target;
            end
        end
    end

    // Reads see pre-edge table contents, so a same-cycle update is not visible until the next lookup.
    always_ff @(posedge clk) begin
        if (!rst || state == INIT) begin
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_hist   <= '0;
        end else if (!lk_stall) begin
            pred_taken  <= lk_valid & bp_enable & lk_hit & cnt_mem[lk_idx][CNT_BITS-1];
            pred_target <= (lk_valid && lk_hit) ? tgt_mem[lk_idx] : lk_pc + 32'd4;
            pred_hist   <= hist_now;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared against an array-based reference model of the predictor rules.
module tb_branch_predictor;
    localparam int ENTRIES  = 64;
    localparam int CNT_BITS = 2;
    localparam int TAG_BITS = 8;
    localparam int GHR_BITS = 6;
    localparam int IDX_BITS = 6;
    localparam int CMAX     = (1 << CNT_BITS) - 1;
    localparam int WNT      = (1 << (CNT_BITS - 1)) - 1;
    localparam int WT       = WNT + 1;
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                bp_enable;
    logic                ready;
    logic                lk_valid;
    logic [31:0]         lk_pc;
    logic                lk_stall;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic [GHR_BITS-1:0] pred_hist;
    logic                upd_valid;
    logic [31:0]         upd_pc;
    logic                upd_taken;
    logic [31:0]         upd_target;
    logic [GHR_BITS-1:0] upd_hist;

    branch_predictor #(
        .ENTRIES(ENTRIES), .CNT_BITS(CNT_BITS), .TAG_BITS(TAG_BITS), .GHR_BITS(GHR_BITS)
    ) dut (
        .clk(clk), .rst(rst), .bp_enable(bp_enable), .ready(ready),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_stall(lk_stall),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_hist(pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_hist(upd_hist)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int unsigned m_ghr;

    logic                exp_taken;
    logic [31:0]         exp_target;
    logic [GHR_BITS-1:0] exp_hist;

    function automatic int unsigned idxOf(input logic [31:0] pc, input int unsigned hist);
        return ((pc >> 2) % ENTRIES) ^ (GSHARE ? (hist % (1 << GHR_BITS)) : 0);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return (pc >> (2 + IDX_BITS)) % (1 << TAG_BITS);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = WNT;
        end
        m_ghr      = 0;
        exp_taken  = 1'b0;
        exp_target = '0;
        exp_hist   = '0;
    endtask

    task automatic checkValue(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    task automatic checkOutput(input string name);
        checkValue({name, "_taken"}, 32'(pred_taken), 32'(exp_taken));
        checkValue({name, "_target"}, pred_target, exp_target);
        checkValue({name, "_hist"}, 32'(pred_hist), 32'(exp_hist));
    endtask

    // One clock of traffic; expected outputs come from the model before it absorbs the update.
    task automatic applyStimulus(input logic lv, input logic [31:0] lpc, input logic stall,
                                 input logic en, input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utgt,
                                 input logic [GHR_BITS-1:0] uh);
        int unsigned i, j;
        bit hit;
        lk_valid = lv; lk_pc = lpc; lk_stall = stall; bp_enable = en;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; upd_hist = uh;
        if (!stall) begin
            i = idxOf(lpc, m_ghr);
            hit = m_valid[i] && (m_tag[i] == tagOf(lpc));
            exp_taken  = lv && en && hit && (m_cnt[i] >= WT);
            exp_target = (lv && hit) ? m_tgt[i] : lpc + 32'd4;
            exp_hist   = GSHARE ? GHR_BITS'(m_ghr) : '0;
        end
        @(posedge clk); #1;
        if (uv) begin
            j = idxOf(upc, 32'(uh));
            if (m_valid[j] && m_tag[j] == tagOf(upc)) begin
                if (ut) begin
                    m_cnt[j] = (m_cnt[j] < CMAX) ? m_cnt[j] + 1 : CMAX;
                    m_tgt[j] = utgt;
                end else begin
                    m_cnt[j] = (m_cnt[j] > 0) ? m_cnt[j] - 1 : 0;
                end
            end else if (ut) begin
                m_valid[j] = 1'b1;
                m_tag[j]   = tagOf(upc);
                m_cnt[j]   = WT;
                m_tgt[j]   = utgt;
            end
            m_ghr = ((m_ghr << 1) | 32'(ut)) % (1 << GHR_BITS);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input string name);
        applyStimulus(1'b1, pc, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, '0);
        checkOutput(name);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                          input logic [GHR_BITS-1:0] h, input string name);
        applyStimulus(1'b0, pc + 32'h40, 1'b0, 1'b1, 1'b1, pc, t, tgt, h);
        checkOutput(name);
    endtask

    // Counts edges from release until ready; lookups and updates are driven to prove they are ignored.
    task automatic runInit(input string name);
        int cycles;
        cycles = 0;
        lk_valid = 1'b1; lk_pc = 32'h4000_0010; lk_stall = 1'b0; bp_enable = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h4000_0010; upd_taken = 1'b1;
        upd_target = 32'hDEAD_0000; upd_hist = '0;
        rst = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            cycles++;
            checkValue({name, "_pred_taken_low"}, 32'(pred_taken), 32'h0);
            if (ready) break;
        end
        checkValue({name, "_cycles"}, 32'(cycles), 32'(ENTRIES));
        upd_valid = 1'b0; lk_valid = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [31:0] a, q, pc, upc;
        rst = 1'b0; bp_enable = 1'b0; lk_valid = 1'b0; lk_pc = '0; lk_stall = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_hist = '0;
        modelReset();

        repeat (3) begin @(posedge clk); #1; end
        checkValue("reset_ready", 32'(ready), 32'h0);
        checkValue("reset_taken", 32'(pred_taken), 32'h0);
        checkValue("reset_target", pred_target, 32'h0);
        checkValue("reset_hist", 32'(pred_hist), 32'h0);
        runInit("init");

        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checkValue("mid_sweep_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkValue("restart_ready", 32'(ready), 32'h0);
        runInit("reinit");

        // Cold allocate and a miss on the neighbouring PC.
        update(32'h4000_0010, 1'b1, 32'h4000_0100, '0, "cold_upd");
        lookup(32'h4000_0010, "cold_hit");
`ifndef BP_GSHARE_EN
        checkValue("cold_hit_lit_taken", 32'(pred_taken), 32'h1);
        checkValue("cold_hit_lit_target", pred_target, 32'h4000_0100);
`endif
        lookup(32'h4000_0014, "cold_miss");
`ifndef BP_GSHARE_EN
        checkValue("cold_miss_lit_target", pred_target, 32'h4000_0018);
`endif

        // Saturation and hysteresis on one entry.
        pc = 32'h0000_0100;
        repeat (4) update(pc, 1'b1, 32'h0000_0800, '0, "sat_up");
        update(pc, 1'b0, 32'h0, '0, "sat_nt1");
        lookup(pc, "sat_after_nt1");
`ifndef BP_GSHARE_EN
        checkValue("sat_nt1_lit", 32'(pred_taken), 32'h1);
`endif
        update(pc, 1'b0, 32'h0, '0, "sat_nt2");
        lookup(pc, "sat_after_nt2");
`ifndef BP_GSHARE_EN
        checkValue("sat_nt2_lit", 32'(pred_taken), 32'h0);
`endif
        repeat (5) update(pc, 1'b0, 32'h0, '0, "sat_down");
        update(pc, 1'b1, 32'h0000_0800, '0, "sat_floor_up");
        lookup(pc, "sat_floor");
`ifndef BP_GSHARE_EN
        checkValue("sat_floor_lit", 32'(pred_taken), 32'h0);
`endif

        // Tag aliasing: replacement on taken, untouched on not-taken.
        a = 32'h0000_020C;
        update(a, 1'b1, 32'h0000_1000, '0, "alias_alloc");
        lookup(a, "alias_hit_a");
        update(a + ENTRIES * 4, 1'b1, 32'h0000_2000, '0, "alias_replace");
        lookup(a, "alias_lookup_a");
`ifndef BP_GSHARE_EN
        checkValue("alias_a_lit", 32'(pred_taken), 32'h0);
`endif
        update(a + ENTRIES * 8, 1'b0, 32'h0, '0, "alias_nt");
        lookup(a + ENTRIES * 4, "alias_kept");

        // Enable gating, output hold while stalled, read-old on a same-cycle collision.
        applyStimulus(1'b1, a + ENTRIES * 4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, '0);
        checkOutput("bp_disabled");
        lookup(a + ENTRIES * 4, "pre_stall");
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b1, 32'h4000_0000 + 32'(s * 4), 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, '0);
            checkOutput("stall_hold");
        end
        q = 32'h4000_0030;
        applyStimulus(1'b1, q, 1'b0, 1'b1, 1'b1, q, 1'b1, 32'h0000_5000, '0);
        checkOutput("same_cycle_old");
        lookup(q, "same_cycle_new");

        // Randomized traffic over a small PC pool so hits, aliases and collisions recur.
        for (int n = 0; n < 400; n++) begin
            pc  = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            upc = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 7) == 0),
                          1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), upc,
                          1'($urandom_range(0, 2) != 0), $urandom, GHR_BITS'($urandom));
            checkOutput("rand");
        end

`ifdef BP_GSHARE_EN
        rst = 1'b0;
        @(posedge clk); #1;
        runInit("gshare_init");
        repeat (6) update(32'h0000_1000, 1'b1, 32'h0000_3000, '0, "gshare_fill");
        lookup(32'h0000_2014, "gshare_lookup");
        checkValue("gshare_hist_lit", 32'(pred_hist), 32'h3F);
        update(32'h0000_2014, 1'b1, 32'h2222_0000, 6'h3F, "gshare_train");
        lookup(32'h0000_2014, "gshare_hit");
        checkValue("gshare_hit_lit_taken", 32'(pred_taken), 32'h1);
        checkValue("gshare_hit_lit_target", pred_target, 32'h2222_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
